// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory responder: AW/W bursts commit to a byte-strobed RAM, AR bursts stream it back.
// Optional macro EI_AXI4_SLV_ERR_RESP_EN adds range/wlast checking with SLVERR responses.
module ei_axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [1:0]              w_state_dbg,
  output logic                    r_state_dbg
);
  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // every ready/valid driven here is a register, so a sender may sample it on the previous falling edge.
  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef EI_AXI4_SLV_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst);
    logic [2:0]            eff;
    logic [ADDR_WIDTH-1:0] step, mask, inc;
    eff  = (size > 3'(LANE_BITS)) ? 3'(LANE_BITS) : size;
    step = ADDR_WIDTH'(1) << eff;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << eff) - ADDR_WIDTH'(1);
    inc  = addr + step;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    word_idx = IDX_W'(addr >> LANE_BITS);
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    in_range = (addr >> LANE_BITS) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  // Write channel
  w_state_t              w_state, w_state_d;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_d;
  logic [7:0]            w_len, w_len_d, w_cnt, w_cnt_d;
  logic [2:0]            w_size, w_size_d;
  logic [1:0]            w_burst, w_burst_d, bresp_d;
  logic                  w_err, w_err_d, awready_d, wready_d, bvalid_d;
  logic                  w_fire, w_ok, beat_err;

  assign w_fire   = (w_state == W_DATA) && wvalid && wready;
  assign w_ok     = !ERR_EN || in_range(w_addr);
  assign beat_err = ERR_EN && (!in_range(w_addr) || (wlast != (w_cnt == w_len)));

  always_comb begin
    w_state_d = w_state;
    w_addr_d  = w_addr;
    w_len_d   = w_len;
    w_size_d  = w_size;
    w_burst_d = w_burst;
    w_cnt_d   = w_cnt;
    w_err_d   = w_err;
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready) begin
          w_addr_d  = awaddr;
          w_len_d   = awlen;
          w_size_d  = awsize;
          w_burst_d = awburst;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          w_addr_d = next_addr(w_addr, w_size, w_len, w_burst);
          w_cnt_d  = w_cnt + 8'd1;
          w_err_d  = w_err | beat_err;
          if (w_cnt == w_len) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (w_err | beat_err) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid && bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      w_state <= w_state_d;
      w_addr  <= w_addr_d;
      w_len   <= w_len_d;
      w_size  <= w_size_d;
      w_burst <= w_burst_d;
      w_cnt   <= w_cnt_d;
      w_err   <= w_err_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
    end
  end

  // RAM is never cleared; beats already written before a reset stay committed.
  always_ff @(posedge aclk) begin
    if (aresetn && w_fire && w_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read channel: the RAM is read before this edge's write lands, giving old data on a collision.
  r_state_t              r_state, r_state_d;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_d, rd_addr;
  logic [7:0]            r_len, r_len_d, r_cnt, r_cnt_d;
  logic [2:0]            r_size, r_size_d;
  logic [1:0]            r_burst, r_burst_d, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_d, rd_word;
  logic                  arready_d, rvalid_d, rlast_d, rd_ok;

  assign rd_addr = (r_state == R_IDLE) ? araddr : r_addr;
  assign rd_ok   = !ERR_EN || in_range(rd_addr);
  assign rd_word = mem[word_idx(rd_addr)];

  always_comb begin
    r_state_d = r_state;
    r_addr_d  = r_addr;
    r_len_d   = r_len;
    r_size_d  = r_size;
    r_burst_d = r_burst;
    r_cnt_d   = r_cnt;
    arready_d = arready;
    rvalid_d  = rvalid;
    rlast_d   = rlast;
    rdata_d   = rdata;
    rresp_d   = rresp;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready) begin
          r_len_d   = arlen;
          r_size_d  = arsize;
          r_burst_d = arburst;
          r_addr_d  = next_addr(araddr, arsize, arlen, arburst);
          r_cnt_d   = '0;
          rvalid_d  = 1'b1;
          rlast_d   = (arlen == 8'd0);
          rdata_d   = rd_ok ? rd_word : '0;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid && rready) begin
          if (rlast) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = r_cnt + 8'd1;
            rlast_d  = ((r_cnt + 8'd1) == r_len);
            rdata_d  = rd_ok ? rd_word : '0;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_addr_d = next_addr(r_addr, r_size, r_len, r_burst);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      r_state <= r_state_d;
      r_addr  <= r_addr_d;
      r_len   <= r_len_d;
      r_size  <= r_size_d;
      r_burst <= r_burst_d;
      r_cnt   <= r_cnt_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rlast   <= rlast_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
    end
  end

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed bench for ei_axi4_slave_mem: INCR/WRAP/FIXED bursts, strobes, read stalls, concurrency,
// and the out-of-range behaviour that depends on EI_AXI4_SLV_ERR_RESP_EN.
module tb_ei_axi4_slave_mem;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [1:0]  w_state_dbg;
  logic        r_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wbeats[16];
  logic [3:0]  wstrbs[16];
  logic [31:0] rexp[16];

  ei_axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // Clock and watchdog
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one write burst from wbeats/wstrbs; checks B timing and response.
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [1:0] exp_resp);
    @(negedge aclk);
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    for (int t = 0; t < 50 && awready !== 1'b1; t++) @(negedge aclk);
    check("aw_wait", awready, 1'b1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbeats[i]; wstrb = wstrbs[i]; wlast = (i == int'(len)); wvalid = 1'b1;
      for (int t = 0; t < 50 && wready !== 1'b1; t++) @(negedge aclk);
      check("w_wait", wready, 1'b1);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_after_last", bvalid, 1'b1);
    check("wready_after_last", wready, 1'b0);
    check("bresp", bresp, exp_resp);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_clear", bvalid, 1'b0);
    check("awready_after_b", awready, 1'b1);
  endtask

  // Issues one read burst and checks every presented beat against rexp; stall uses rready 1,0,0,...
  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [1:0] exp_resp, input bit stall);
    int beat;
    int k;
    @(negedge aclk);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int t = 0; t < 50 && arready !== 1'b1; t++) @(negedge aclk);
    check("ar_wait", arready, 1'b1);
    @(negedge aclk);
    arvalid = 1'b0;
    beat = 0;
    k = 0;
    while (beat <= int'(len) && k < 200) begin
      rready = stall ? (k % 3 == 0) : 1'b1;
      check("rvalid", rvalid, 1'b1);
      check("rdata", rdata, rexp[beat]);
      check("rresp", rresp, exp_resp);
      check("rlast", rlast, (beat == int'(len)));
      if (rready) beat++;
      k++;
      @(negedge aclk);
    end
    rready = 1'b0;
    check("r_beats", beat, int'(len) + 1);
    check("rvalid_clear", rvalid, 1'b0);
    check("arready_after_r", arready, 1'b1);
  endtask

  initial begin
    // Reset held three cycles
    repeat (3) @(negedge aclk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_bresp", bresp, 2'b00);
    check("rst_rresp", rresp, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_w_state", w_state_dbg, 2'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_awready", awready, 1'b1);
    check("post_rst_arready", arready, 1'b1);

    // INCR len=3 at 0x10, read back
    for (int i = 0; i < 4; i++) begin
      wbeats[i] = 32'hA0 + 32'(i); wstrbs[i] = 4'hF; rexp[i] = 32'hA0 + 32'(i);
    end
    write_burst(32'h10, 8'd3, 3'd2, 2'b01, 2'b00);
    read_burst(32'h10, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);

    // WRAP len=3 at 0x38 lands at 0x38,0x3C,0x30,0x34
    wbeats[0] = 32'hB0; wbeats[1] = 32'hB1; wbeats[2] = 32'hB2; wbeats[3] = 32'hB3;
    write_burst(32'h38, 8'd3, 3'd2, 2'b10, 2'b00);
    rexp[0] = 32'hB2; rexp[1] = 32'hB3; rexp[2] = 32'hB0; rexp[3] = 32'hB1;
    read_burst(32'h30, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0);
    rexp[0] = 32'hB0; rexp[1] = 32'hB1; rexp[2] = 32'hB2; rexp[3] = 32'hB3;
    read_burst(32'h38, 8'd3, 3'd2, 2'b10, 2'b00, 1'b0);

    // Byte strobes on word 0
    wbeats[0] = 32'hDEADBEEF; wstrbs[0] = 4'hF;
    write_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'b00);
    wbeats[0] = 32'h11223344; wstrbs[0] = 4'h3;
    write_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'b00);
    rexp[0] = 32'hDEAD3344;
    read_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);

    // FIXED burst: both beats hit 0x40
    wbeats[0] = 32'h12345678; wstrbs[0] = 4'hF;
    wbeats[1] = 32'h000000AB; wstrbs[1] = 4'h1;
    write_burst(32'h40, 8'd1, 3'd2, 2'b00, 2'b00);
    rexp[0] = 32'h123456AB; rexp[1] = 32'h123456AB;
    read_burst(32'h40, 8'd1, 3'd2, 2'b00, 2'b00, 1'b0);

    // Stalled 8-beat read with a concurrent single-beat write
    for (int i = 0; i < 8; i++) begin
      wbeats[i] = 32'hC0 + 32'(i); wstrbs[i] = 4'hF; rexp[i] = 32'hC0 + 32'(i);
    end
    write_burst(32'h100, 8'd7, 3'd2, 2'b01, 2'b00);
    wbeats[0] = 32'h5555AAAA; wstrbs[0] = 4'hF;
    fork
      write_burst(32'h200, 8'd0, 3'd2, 2'b01, 2'b00);
      read_burst(32'h100, 8'd7, 3'd2, 2'b01, 2'b00, 1'b1);
    join
    rexp[0] = 32'h5555AAAA;
    read_burst(32'h200, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);

    // Word index 1024: out of range or aliased onto word 0
    wbeats[0] = 32'hCAFEF00D; wstrbs[0] = 4'hF;
`ifdef EI_AXI4_SLV_ERR_RESP_EN
    write_burst(32'h1000, 8'd0, 3'd2, 2'b01, 2'b10);
    rexp[0] = 32'hDEAD3344;
    read_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);
    rexp[0] = 32'h0;
    read_burst(32'h1000, 8'd0, 3'd2, 2'b01, 2'b10, 1'b0);
`else
    write_burst(32'h1000, 8'd0, 3'd2, 2'b01, 2'b00);
    rexp[0] = 32'hCAFEF00D;
    read_burst(32'h0, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);
    read_burst(32'h1000, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
